// File: rtl/pzc_peak_readout_pkg.sv
// Shared defaults and peak-record layout for the PZC peak readout block.
package pzc_readout_pkg;

    localparam int PZC_DATA_BITS = 29;
    localparam int PZC_BCID_BITS = 12;
    localparam int PZC_BUNCH_POS = 3564;

    localparam int AMP_LSB  = 0;
    localparam int BCID_LSB = PZC_DATA_BITS;

    typedef struct packed {
        logic        [PZC_BCID_BITS-1:0] bcid;
        logic signed [PZC_DATA_BITS-1:0] amp;
    } pzc_peak_rec_t;

endpackage

// File: rtl/pzc_peak_readout_fifo.sv
// First-word-fall-through synchronous FIFO holding peak records for the HPS.
module readout_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pzc_peak_readout.sv
// BCID tagging and local-maximum peak detection on the PZC stream, queued for HPS readout.
// Optional build macro PZC_PEAK_BT_MASK_EN restricts pushed peaks to the bunch train.
module pzc_peak_readout
    import pzc_readout_pkg::*;
#(
    parameter int DATA_BITS  = PZC_DATA_BITS,
    parameter int BCID_BITS  = PZC_BCID_BITS,
    parameter int BUNCH_POS  = PZC_BUNCH_POS,
    parameter int FIFO_DEPTH = 16,
    parameter int OVF_BITS   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic signed [DATA_BITS-1:0]      in_data,
    input  logic                             bt_mask_in,
    input  logic signed [DATA_BITS-1:0]      threshold,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [DATA_BITS+BCID_BITS-1:0]   rd_data,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic [OVF_BITS-1:0]              ovf_count,
    output logic                             orbit_tick
);

    localparam int REC_BITS = DATA_BITS + BCID_BITS;
    localparam logic [BCID_BITS-1:0] BCID_LAST = BCID_BITS'(BUNCH_POS - 1);

    function automatic logic [OVF_BITS-1:0] sat_inc(input logic [OVF_BITS-1:0] v);
        return (&v) ? v : v + OVF_BITS'(1);
    endfunction

    logic [BCID_BITS-1:0]        bcid;
    logic signed [DATA_BITS-1:0] s1;
    logic signed [DATA_BITS-1:0] s2;
    logic [BCID_BITS-1:0]        b1;
    logic [1:0]                  fill;
    logic                        in_train;
    logic                        peak;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [REC_BITS-1:0]         rec;

    // The live input acts as the newest tap s0, so a peak held in s1 is pushed
    // on the same edge that its successor is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcid       <= '0;
            orbit_tick <= 1'b0;
            s1         <= '0;
            s2         <= '0;
            b1         <= '0;
            fill       <= '0;
        end else if (enable) begin
            bcid       <= (bcid == BCID_LAST) ? '0 : bcid + BCID_BITS'(1);
            orbit_tick <= (bcid == BCID_LAST);
            s1         <= in_data;
            s2         <= s1;
            b1         <= bcid;
            if (fill != 2'd2) fill <= fill + 2'd1;
        end else begin
            orbit_tick <= 1'b0;
        end
    end

`ifdef PZC_PEAK_BT_MASK_EN
    logic m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         m1 <= 1'b0;
        else if (enable) m1 <= bt_mask_in;
    end

    assign in_train = m1;
`else
    logic unused_bt_mask;
    assign unused_bt_mask = bt_mask_in;
    assign in_train       = 1'b1;
`endif

    // Strict on the older side, inclusive on the newer: a plateau reports its first sample.
    assign peak = enable && (fill == 2'd2) && in_train
                  && (s1 > threshold) && (s1 > s2) && (s1 >= in_data);

    assign rec = {b1, s1};

    readout_fifo #(
        .WIDTH (REC_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (peak),
        .push_data (rec),
        .pop       (rd_ready),
        .head      (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rd_valid = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          ovf_count <= '0;
        else if (peak && fifo_full && !rd_ready) ovf_count <= sat_inc(ovf_count);
    end

endmodule

// File: tb/tb_pzc_peak_readout.sv
// Directed and randomized bench for pzc_peak_readout against a queue-based reference model.
module tb_pzc_peak_readout;
    import pzc_readout_pkg::*;

    localparam int DB = 29;
    localparam int BB = 12;
    localparam int BP = 3564;
    localparam int FD = 16;
    localparam int OB = 16;
    localparam int RB = DB + BB;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic signed [DB-1:0] in_data;
    logic                 bt_mask_in;
    logic signed [DB-1:0] threshold;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [RB-1:0]        rd_data;
    logic [4:0]           fifo_count;
    logic [OB-1:0]        ovf_count;
    logic                 orbit_tick;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int v;
        int b;
        bit m;
    } samp_t;

    samp_t         hist[$];
    logic [RB-1:0] mq[$];
    int            n_en  = 0;
    int            m_ovf = 0;
    bit            m_tick = 1'b0;
    int            thr_i  = 0;

    pzc_peak_readout dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_data    (in_data),
        .bt_mask_in (bt_mask_in),
        .threshold  (threshold),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .fifo_count (fifo_count),
        .ovf_count  (ovf_count),
        .orbit_tick (orbit_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [RB-1:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : '0;
        chk({tag, ".rd_valid"},   64'(rd_valid),   64'(mq.size() > 0));
        chk({tag, ".rd_data"},    64'(rd_data),    64'(exp_data));
        chk({tag, ".fifo_count"}, 64'(fifo_count), 64'(mq.size()));
        chk({tag, ".ovf_count"},  64'(ovf_count),  64'(m_ovf));
        chk({tag, ".orbit_tick"}, 64'(orbit_tick), 64'(m_tick));
    endtask

    task automatic model_clear();
        hist.delete();
        mq.delete();
        n_en   = 0;
        m_ovf  = 0;
        m_tick = 1'b0;
    endtask

    task automatic set_thr(input int t);
        thr_i     = t;
        threshold = DB'(t);
    endtask

    // One clock: drive at the falling edge, predict, clock, then compare at the next falling edge.
    task automatic step(input bit en, input int d, input bit m, input bit rdy, input string tag);
        bit            pop;
        bit            push;
        bit            train;
        samp_t         p;
        samp_t         o;
        logic [RB-1:0] rec;
        enable     = en;
        in_data    = DB'(d);
        bt_mask_in = m;
        rd_ready   = rdy;
        pop  = rdy && (mq.size() > 0);
        push = 1'b0;
        rec  = '0;
        if (en && hist.size() >= 2) begin
            p = hist[hist.size()-1];
            o = hist[hist.size()-2];
            train = 1'b1;
`ifdef PZC_PEAK_BT_MASK_EN
            train = p.m;
`endif
            if (train && p.v > thr_i && p.v > o.v && p.v >= d) begin
                push = 1'b1;
                rec  = {BB'(p.b), DB'(p.v)};
            end
        end
        @(posedge clk);
        if (pop) mq.delete(0);
        if (push) begin
            if (mq.size() < FD) mq.push_back(rec);
            else if (m_ovf < 65535) m_ovf++;
        end
        if (en) begin
            hist.push_back('{d, n_en % BP, m});
            if (hist.size() > 3) hist.delete(0);
            n_en++;
            m_tick = (n_en % BP == 0);
        end else begin
            m_tick = 1'b0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Assert reset between edges, check the immediate effect, release at the next falling edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        pzc_peak_rec_t r;
        int            b_first;
        int            tick_cnt;
        logic [RB-1:0] seen;
        bit            seen_any;

        rst        = 1'b1;
        enable     = 1'b0;
        in_data    = '0;
        bt_mask_in = 1'b0;
        rd_ready   = 1'b0;
        set_thr(0);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single peak: 300 at BCID 10.
        set_thr(100);
        for (int i = 0; i < 9; i++) step(1, 0, 1, 0, "single");
        step(1, 50, 1, 0, "single");
        step(1, 300, 1, 0, "single");
        chk("single.not_yet", 64'(rd_valid), 64'(0));
        step(1, 120, 1, 0, "single");
        r = rd_data;
        chk("single.valid", 64'(rd_valid), 64'(1));
        chk("single.bcid", 64'(r.bcid), 64'(10));
        chk("single.amp", 64'(r.amp), 64'(300));
        step(1, 0, 1, 0, "single");
        chk("single.count", 64'(fifo_count), 64'(1));
        step(1, 0, 1, 1, "single_drain");
        chk("single.drained", 64'(fifo_count), 64'(0));

        // Plateau and threshold-equal sample.
        step(1, 0, 1, 0, "plateau");
        b_first = n_en % BP;
        step(1, 200, 1, 0, "plateau");
        step(1, 200, 1, 0, "plateau");
        step(1, 0, 1, 0, "plateau");
        step(1, 0, 1, 0, "plateau");
        r = rd_data;
        chk("plateau.count", 64'(fifo_count), 64'(1));
        chk("plateau.bcid", 64'(r.bcid), 64'(b_first));
        chk("plateau.amp", 64'(r.amp), 64'(200));
        step(1, 100, 1, 0, "thr_eq");
        step(1, 0, 1, 0, "thr_eq");
        step(1, 0, 1, 0, "thr_eq");
        chk("thr_eq.count", 64'(fifo_count), 64'(1));
        step(1, 0, 1, 1, "thr_drain");

        // Overflow: 20 isolated peaks with no reads.
        for (int i = 0; i < 20; i++) begin
            step(1, 500, 1, 0, "ovf");
            step(1, 0, 1, 0, "ovf");
        end
        chk("ovf.count", 64'(fifo_count), 64'(16));
        chk("ovf.ovf", 64'(ovf_count), 64'(4));
        for (int i = 0; i < 16; i++) step(1, 0, 1, 1, "ovf_drain");
        chk("ovf.empty", 64'(rd_valid), 64'(0));
        for (int i = 0; i < 16; i++) begin
            step(1, 500, 1, 0, "refill");
            step(1, 0, 1, 0, "refill");
        end
        step(1, 500, 1, 0, "full_pop_push");
        step(1, 0, 1, 1, "full_pop_push");
        chk("fpp.count", 64'(fifo_count), 64'(16));
        chk("fpp.ovf", 64'(ovf_count), 64'(4));
        for (int i = 0; i < 17; i++) step(1, 0, 1, 1, "fpp_drain");

        // Randomized traffic with enable gaps, backpressure and threshold changes.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) set_thr($urandom_range(0, 400) - 200);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 800) - 300,
                 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, "random");
        end

        // Reset mid-operation with records queued.
        set_thr(100);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, "pre_rst");
            step(1, 500, 1, 0, "pre_rst");
        end
        step(1, 0, 1, 0, "pre_rst");
        async_reset("mid_rst");
        chk("mid_rst.valid", 64'(rd_valid), 64'(0));
        step(1, 800, 1, 0, "post_rst");
        step(1, 0, 1, 0, "post_rst");
        step(1, 0, 1, 0, "post_rst");
        step(1, 0, 1, 0, "post_rst");
        chk("post_rst.no_peak", 64'(fifo_count), 64'(0));
        step(1, 500, 1, 0, "post_rst");
        step(1, 0, 1, 0, "post_rst");
        r = rd_data;
        chk("post_rst.bcid", 64'(r.bcid), 64'(4));
        step(1, 0, 1, 1, "post_rst");

        // Bunch-train mask: peaks at BCID 10 (outside) and 20 (inside).
        async_reset("mask_rst");
        for (int i = 0; i < 23; i++) begin
            if (i == 10)      step(1, 500, 0, 0, "mask");
            else if (i == 20) step(1, 500, 1, 0, "mask");
            else              step(1, 0, 1, 0, "mask");
        end
        r = rd_data;
`ifdef PZC_PEAK_BT_MASK_EN
        chk("mask.count", 64'(fifo_count), 64'(1));
        chk("mask.bcid", 64'(r.bcid), 64'(20));
`else
        chk("mask.count", 64'(fifo_count), 64'(2));
        chk("mask.bcid", 64'(r.bcid), 64'(10));
`endif
        chk("mask.ovf", 64'(ovf_count), 64'(0));
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, "mask_drain");

        // BCID wrap with a peak at the last bunch position.
        async_reset("wrap_rst");
        tick_cnt = 0;
        seen     = '0;
        seen_any = 1'b0;
        for (int i = 0; i < 3566; i++) begin
            step(1, (i == BP - 1) ? 500 : 0, 1, 1, "wrap");
            if (orbit_tick) begin
                tick_cnt++;
                chk("wrap.tick_at", 64'(i), 64'(BP - 1));
            end
            if (rd_valid && !seen_any) begin
                seen     = rd_data;
                seen_any = 1'b1;
            end
        end
        r = seen;
        chk("wrap.ticks", 64'(tick_cnt), 64'(1));
        chk("wrap.rec_seen", 64'(seen_any), 64'(1));
        chk("wrap.bcid", 64'(r.bcid), 64'(BP - 1));
        chk("wrap.amp", 64'(r.amp), 64'(500));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pzc_peak_readout.md
Name: pzc_peak_readout

Overview:
- Downstream consumer of the simulator's PZC output (pzc_out, bt_mask_out).
- Tags every clock with a bunch-crossing ID (BCID) and detects local maxima of the PZC signal above a programmable threshold.
- Packs each detected peak with its BCID into a small FIFO that the HPS reads over a valid/ready handshake.

Parameters:
- DATA_BITS, 29: width of the signed PZC sample (CLIP_OUT_BITS+1+16).
- BCID_BITS, 12: BCID counter width.
- BUNCH_POS, 3564: bunch positions per orbit; BCID wraps at BUNCH_POS-1.
- FIFO_DEPTH, 16: peak record FIFO entries; power of two.
- OVF_BITS, 16: width of the saturating drop counter.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- enable, input, 1: run; when low, the BCID counter holds and no peaks are detected.
- in_data, input, DATA_BITS signed: PZC sample, one per clk.
- bt_mask_in, input, 1: bunch-train mask aligned with in_data.
- threshold, input, DATA_BITS signed: peak amplitude threshold, sampled every cycle.
- rd_valid, output, 1: FIFO head holds a record.
- rd_ready, input, 1: HPS accepts the head record.
- rd_data, output, DATA_BITS+BCID_BITS: record {bcid, amplitude}; BCID in the MSBs.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- ovf_count, output, OVF_BITS: records dropped because the FIFO was full.
- orbit_tick, output, 1: one-cycle pulse when BCID wraps to 0.

Behaviour:
- Reset: all outputs are 0. This covers rd_valid, rd_data, fifo_count, ovf_count and orbit_tick. The BCID counter, the sample window and the FIFO pointers are also cleared. Reset asserted mid-operation discards FIFO contents immediately.
- BCID counter:
  - Increments by 1 each enabled cycle.
  - At BUNCH_POS-1 it wraps to 0, and orbit_tick pulses in the cycle the counter reads 0.
- Sample window:
  - Registers s0 (newest), s1, s2 and their BCIDs b0, b1, b2. All shift only when enable=1.
  - The window is invalid for the first 2 enabled cycles after reset. A fill counter gates detection.
- Peak condition (signed compare): s1 > threshold AND s1 > s2 AND s1 >= s0.
  - The ">=" on the newest side means a flat-top plateau reports its first sample only.
- Latency: a peak at input cycle N is pushed into the FIFO at the clock edge ending cycle N+1. It carries BCID b1 (the BCID of sample N), not the current BCID. It is visible on rd_valid at N+2 when the FIFO was empty.
- BCID wrap: a peak straddling a wrap keeps its own BCID, e.g. 3563 or 0 as appropriate.
- FIFO:
  - Synchronous, first-word-fall-through.
  - rd_data is always the head entry; it is 0 when empty.
  - A pop occurs when rd_valid && rd_ready. rd_ready while empty is ignored.
- Full:
  - A push while full and without a simultaneous pop is dropped, and ovf_count increments, saturating at all-ones.
  - A push while full with a simultaneous pop is accepted; count is unchanged.
- Empty: a push and pop in the same cycle cannot occur, since rd_valid=0. A push makes rd_valid=1 on the next cycle.
- fifo_count updates with the registered pointers; its range is 0..FIFO_DEPTH.
- enable low: the window and BCID freeze, no push occurs, and FIFO reads continue normally.

Optional Feature:
- Macro: PZC_PEAK_BT_MASK_EN.
- When defined: the mask is delayed alongside the window (m1). A peak is pushed only if m1=1, and peaks outside the bunch train are silently discarded; ovf_count is not touched.
- When undefined: bt_mask_in is unused, and every qualifying peak is pushed.

Decomposition:
- Package pzc_readout_pkg holds:
  - DATA_BITS, BCID_BITS and BUNCH_POS defaults;
  - record field offsets (AMP_LSB=0, BCID_LSB=DATA_BITS);
  - a packed record typedef pzc_peak_rec_t.
- One sub-module: readout_fifo, a parameterised FWFT synchronous FIFO with push/pop/full/empty/count.
- Detection and BCID logic stay in the top module.

Test Plan:
- BCID wrap: hold enable=1 for 3565 cycles → BCID goes 3563→0 and orbit_tick pulses exactly once, at the wrap cycle.
- Single peak: threshold=100, samples 0, 50, 300, 120, 0 with the 300 at BCID 10 → exactly one record {bcid=10, amp=300}. rd_valid rises 2 cycles after the 300 is presented.
- Plateau and threshold:
  - samples 0, 200, 200, 0 with threshold=100 → one record, at the first 200;
  - samples 0, 100, 0 with threshold=100 → no record.
- Overflow: rd_ready=0 and 20 isolated peaks → fifo_count=16, ovf_count=4, and the first 16 records are read back in order. Then drive a full-plus-pop-plus-push cycle → count stays 16 and ovf_count stays unchanged.
- Reset mid-operation: 5 records queued, rst pulsed asynchronously between edges → rd_valid=0, fifo_count=0, BCID=0 immediately. The first 2 samples after release produce no peak.
- With PZC_PEAK_BT_MASK_EN: peak at BCID 10 with mask=0 and peak at BCID 20 with mask=1 → only the BCID-20 record appears. Without the macro, both appear.
